data_mem_lsu: RTL and testbench
===============================

Name: data_mem_lsu

Overview:
- Load/store unit between the riscv32i core's memory stage and the data-memory BRAM port.
- Accepts one RV32I load/store request per transaction and rebases the address by memory_offset.
- Generates byte write enables and lane-replicated store data, and drives the 1-cycle-latency BRAM port.
- Extracts and sign- or zero-extends load data, and reports misaligned, out-of-range and illegal-size accesses without touching memory.

Parameters:
- MEM_DEPTH, 4096, data BRAM depth in 32-bit words; legal rebased byte range is 0 .. MEM_DEPTH*4-1.

Ports:
- clk  in  1  system clock; also forwarded to data_mem_clkb.
- reset  in  1  asynchronous, active-high reset.
- memory_offset  in  32  base byte address of data memory; word-aligned, static after reset.
- req_valid  in  1  request valid.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width code: LB/SB=0, LH/SH=1, LW/SW=2, LBU=4, LHU=5.
- req_addr  in  32  byte address (core view).
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  access rejected.
- data_mem_clkb  out  1  equals clk.
- data_mem_enb  out  1  BRAM enable.
- data_mem_rstb  out  1  tied 0.
- data_mem_web  out  4  byte write enables.
- data_mem_addrb  out  32  rebased byte address.
- data_mem_dinb  out  32  lane-replicated store data.
- data_mem_doutb  in  32  BRAM read data, valid one cycle after the enb edge.
- data_mem_rstb_busy  in  1  BRAM busy; blocks acceptance.

Behaviour:
- Reset (async) values: state=IDLE, enb=0, web=0, addrb=0, dinb=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Reset mid-transaction: the transaction is abandoned immediately with no response, and enb drops without waiting for a clock edge.
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- req_ready = (state==IDLE) && !data_mem_rstb_busy. A request is accepted on the edge where req_valid && req_ready.
- Error checks at accept, with rel = req_addr - memory_offset (32-bit wrap):
  - err if req_addr < memory_offset;
  - err if rel >= MEM_DEPTH*4;
  - err if funct3 is in {3,6,7}, or is in {4,5} with req_we=1;
  - err on halfword access with addr[0]=1;
  - err on word access with addr[1:0]!=0.
- Error path: IDLE -> RESP directly; rsp_err=1, rsp_rdata=0; enb never asserted; response 1 cycle after accept.
- Legal access, IDLE -> ACCESS. All BRAM outputs are registered at the accept edge:
  - enb=1, addrb=rel;
  - load: web=0;
  - SB: web=4'b0001<<rel[1:0], dinb={4{wdata[7:0]}};
  - SH: web=4'b0011<<rel[1:0], dinb={2{wdata[15:0]}};
  - SW: web=4'hF, dinb=wdata.
- ACCESS lasts exactly one cycle (BRAM samples at its closing edge). Then enb=0, web=0, and the state moves to CAPTURE.
- CAPTURE: doutb is valid this cycle and is captured at the closing edge. Load extraction, with off=rel[1:0] held from accept:
  - LB: sign-extend byte[off];
  - LBU: zero-extend byte[off];
  - LH: sign-extend half[off[1]];
  - LHU: zero-extend half[off[1]];
  - LW: doutb.
  - Stores: rsp_rdata=0. Next state RESP.
- Latency: rsp_valid rises 3 edges after the accept edge for legal accesses.
- RESP: rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready. On that edge rsp_valid drops and the state returns to IDLE. A new request can be accepted on the edge after the response handshake, so there is no overlap: one outstanding transaction.
- rstb_busy rising while not in IDLE has no effect on the in-flight access.
- memory_offset is sampled only at accept.

Test Plan:
- memory_offset=0x600; SW addr 0x604 data 0xDEADBEEF -> one enb cycle with web=F, addrb=0x4, dinb=0xDEADBEEF; rsp_valid 3 edges later, rsp_err=0, rsp_rdata=0.
- With word 0x1 holding 0xDEADBEEF: LB 0x607 -> 0xFFFFFFDE; LBU 0x607 -> 0x000000DE; LH 0x606 -> 0xFFFFDEAD; LHU 0x604 -> 0x0000BEEF; LW 0x604 -> 0xDEADBEEF.
- SB 0x605 data 0x000000AA -> web=4'b0010, dinb=0xAAAAAAAA; SH 0x606 data 0x1234 -> web=4'b1100, dinb=0x12341234; subsequent LW 0x604 reflects the merged bytes.
- Error cases (LH 0x601, LW 0x602, LW 0x5FC, LW 0x600+MEM_DEPTH*4, funct3=3, SB-with-funct3=4) -> rsp_err=1, rsp_rdata=0 one cycle after accept; enb never high.
- Backpressure: hold rsp_ready=0 for 3 cycles after rsp_valid -> rsp_valid/rsp_rdata stable, req_ready=0 throughout; a back-to-back request is accepted on the edge following the handshake.
- data_mem_rstb_busy=1 in IDLE -> req_ready=0, no accept. Assert reset during ACCESS -> enb, web and rsp_valid are 0 immediately, no response issued; the first request after reset completes normally.

Source files
------------

// File: rtl/data_mem_lsu.sv
// data_mem_lsu
//   Load/store unit between the riscv32i memory stage and the data BRAM port B.
//   One transaction at a time: a request is accepted in IDLE, checked, and either
//   answered immediately with an error or turned into a single BRAM access whose
//   result is extracted and returned through the response channel.
//
// Handshakes: a request transfers on the rising clk edge where req_valid && req_ready;
//   a response transfers on the edge where rsp_valid && rsp_ready. A valid side keeps
//   its payload stable until the transfer edge.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   memory_offset         base byte address of data memory (sampled at accept)
//   req_*                 request channel (we, funct3 width code, byte address, data)
//   rsp_*                 response channel (extended load data, error flag)
//   data_mem_*            BRAM port B (clock, enable, reset, byte enables, address,
//                         write data, read data, busy)
//   dbg_state             current FSM state, for observation only
module data_mem_lsu #(
  parameter int MEM_DEPTH = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memory_offset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        data_mem_clkb,
  output logic        data_mem_enb,
  output logic        data_mem_rstb,
  output logic [3:0]  data_mem_web,
  output logic [31:0] data_mem_addrb,
  output logic [31:0] data_mem_dinb,
  input  logic [31:0] data_mem_doutb,
  input  logic        data_mem_rstb_busy,
  output logic [1:0]  dbg_state
);

  localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH * 4);

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic        accept;
  logic [31:0] rel;
  logic        below, over, bad_size, misalign, acc_err;
  logic [3:0]  st_web;
  logic [31:0] st_din;

  logic [1:0]  off_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign data_mem_clkb = clk;
  assign data_mem_rstb = 1'b0;
  assign dbg_state     = state_q;
  assign req_ready     = (state_q == IDLE) && !data_mem_rstb_busy;
  assign rsp_valid     = (state_q == RESP);
  assign accept        = req_valid && req_ready;

  // Request decode. rel wraps, so the below-base test must use the raw address.
  always_comb begin
    rel      = req_addr - memory_offset;
    below    = req_addr < memory_offset;
    over     = rel >= MEM_BYTES;
    bad_size = 1'b0;
    misalign = 1'b0;
    case (req_funct3)
      F3_B:  ;
      F3_H:  misalign = req_addr[0];
      F3_W:  misalign = |req_addr[1:0];
      F3_BU: bad_size = req_we;
      F3_HU: begin
        bad_size = req_we;
        misalign = req_addr[0];
      end
      default: bad_size = 1'b1;
    endcase
    acc_err = below | over | bad_size | misalign;
  end

  // Store lane enables and replicated data; only meaningful for legal stores.
  always_comb begin
    st_web = 4'b0000;
    st_din = req_wdata;
    case (req_funct3[1:0])
      2'd0: begin
        st_web = 4'b0001 << rel[1:0];
        st_din = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        st_web = 4'b0011 << rel[1:0];
        st_din = {2{req_wdata[15:0]}};
      end
      2'd2: begin
        st_web = 4'b1111;
        st_din = req_wdata;
      end
      default: begin
        st_web = 4'b0000;
        st_din = req_wdata;
      end
    endcase
  end

  // Load extraction from the BRAM word using the byte offset held from accept.
  always_comb begin
    ld_byte = data_mem_doutb[7:0];
    case (off_q)
      2'd0: ld_byte = data_mem_doutb[7:0];
      2'd1: ld_byte = data_mem_doutb[15:8];
      2'd2: ld_byte = data_mem_doutb[23:16];
      2'd3: ld_byte = data_mem_doutb[31:24];
      default: ld_byte = data_mem_doutb[7:0];
    endcase
    ld_half = off_q[1] ? data_mem_doutb[31:16] : data_mem_doutb[15:0];
    case (funct3_q)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'd0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'd0, ld_half};
      default: ld_data = data_mem_doutb;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = acc_err ? RESP : ACCESS;
        end
      end
      ACCESS:  state_d = CAPTURE;
      CAPTURE: state_d = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // BRAM port and response registers. The async reset drops enb at once, so a
  // reset during ACCESS never lets the BRAM see the access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_mem_enb   <= 1'b0;
      data_mem_web   <= 4'b0000;
      data_mem_addrb <= 32'd0;
      data_mem_dinb  <= 32'd0;
      off_q          <= 2'd0;
      funct3_q       <= 3'd0;
      we_q           <= 1'b0;
      rsp_rdata      <= 32'd0;
      rsp_err        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            off_q     <= rel[1:0];
            funct3_q  <= req_funct3;
            we_q      <= req_we;
            rsp_rdata <= 32'd0;
            rsp_err   <= acc_err;
            if (!acc_err) begin
              data_mem_enb   <= 1'b1;
              data_mem_addrb <= rel;
              data_mem_web   <= req_we ? st_web : 4'b0000;
              if (req_we) begin
                data_mem_dinb <= st_din;
              end
            end
          end
        end
        ACCESS: begin
          data_mem_enb <= 1'b0;
          data_mem_web <= 4'b0000;
        end
        CAPTURE: begin
          rsp_rdata <= we_q ? 32'd0 : ld_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
module tb_data_mem_lsu;

  localparam int          MEM_DEPTH = 4096;
  localparam logic [31:0] OFF       = 32'h600;
  localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH * 4);
  // Edges after the accept edge until rsp_valid is seen (accept edge + 2 = 3 edges).
  localparam int          LEGAL_LAT = 2;

  logic        tb_clk;
  logic        reset;
  logic [31:0] memory_offset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        data_mem_clkb;
  logic        data_mem_enb;
  logic        data_mem_rstb;
  logic [3:0]  data_mem_web;
  logic [31:0] data_mem_addrb;
  logic [31:0] data_mem_dinb;
  logic [31:0] data_mem_doutb;
  logic        data_mem_rstb_busy;
  logic [1:0]  dbg_state;

  int checks;
  int failures;

  data_mem_lsu #(.MEM_DEPTH(MEM_DEPTH)) dut (
    .clk                (tb_clk),
    .reset              (reset),
    .memory_offset      (memory_offset),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_we             (req_we),
    .req_funct3         (req_funct3),
    .req_addr           (req_addr),
    .req_wdata          (req_wdata),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_rdata          (rsp_rdata),
    .rsp_err            (rsp_err),
    .data_mem_clkb      (data_mem_clkb),
    .data_mem_enb       (data_mem_enb),
    .data_mem_rstb      (data_mem_rstb),
    .data_mem_web       (data_mem_web),
    .data_mem_addrb     (data_mem_addrb),
    .data_mem_dinb      (data_mem_dinb),
    .data_mem_doutb     (data_mem_doutb),
    .data_mem_rstb_busy (data_mem_rstb_busy),
    .dbg_state          (dbg_state)
  );

  // ---------------- clock ----------------
  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  // ---------------- BRAM model (read-first, 1-cycle latency) ----------------
  logic [31:0] bram [MEM_DEPTH];
  logic [31:0] bram_w;
  int          bram_idx;
  always @(posedge data_mem_clkb) begin
    if (data_mem_enb) begin
      bram_idx = int'(data_mem_addrb >> 2);
      if (bram_idx < MEM_DEPTH) begin
        bram_w = bram[bram_idx];
        for (int b = 0; b < 4; b++) begin
          if (data_mem_web[b]) bram_w[8*b +: 8] = data_mem_dinb[8*b +: 8];
        end
        data_mem_doutb <= bram[bram_idx];
        bram[bram_idx] <= bram_w;
      end
    end
  end

  // ---------------- reference model: flat byte memory ----------------
  logic [7:0] ref_bytes [MEM_DEPTH*4];

  function automatic void ref_access(input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     output logic err, output logic [31:0] rdata,
                                     output logic [3:0] web, output logic [31:0] dinb);
    int     sz;
    int     rel;
    longint v;
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
    if (f3 == 3'd6 || f3 == 3'd7 || (f3[2] && we)) sz = 0;
    err = (addr < OFF) || ((addr - OFF) >= MEM_BYTES) || (sz == 0);
    if (sz != 0 && (addr % sz) != 0) err = 1'b1;
    rdata = 32'd0;
    web   = 4'd0;
    dinb  = 32'd0;
    if (err) return;
    rel = int'(addr - OFF);
    if (we) begin
      for (int i = 0; i < sz; i++) ref_bytes[rel + i] = wdata[8*i +: 8];
      for (int i = 0; i < 4; i++) begin
        web[i] = (i >= rel % 4) && (i < rel % 4 + sz);
        dinb[8*i +: 8] = wdata[8*(i % sz) +: 8];
      end
    end else begin
      v = 0;
      for (int i = 0; i < sz; i++) v = v | (longint'(ref_bytes[rel + i]) << (8*i));
      if (!f3[2] && sz < 4 && v[8*sz-1]) v = v - (longint'(1) << (8*sz));
      rdata = v[31:0];
    end
  endfunction

  // ---------------- scoreboard helper ----------------
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  // ---------------- driver ----------------
  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          enb_cnt;
    logic [3:0]  web;
    logic [31:0] addrb;
    logic [31:0] dinb;
  } obs_t;

  // Called #1 after a rising edge with the unit idle. Performs one full
  // request/response transaction, holding off rsp_ready for 'hold' cycles.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold, output obs_t o);
    int w;
    logic [31:0] held_rdata;
    logic        held_err;
    o = '{1'b0, 32'd0, 0, 0, 4'd0, 32'd0, 32'd0};
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    w = 0;
    while (!req_ready && w < 20) begin
      @(posedge tb_clk); #1; w++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge tb_clk); #1;
    req_valid = 1'b0;
    while (!rsp_valid && o.lat < 10) begin
      if (data_mem_enb) begin
        o.enb_cnt++;
        o.web   = data_mem_web;
        o.addrb = data_mem_addrb;
        o.dinb  = data_mem_dinb;
      end
      @(posedge tb_clk); #1; o.lat++;
    end
    if (!rsp_valid) chk("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
    if (data_mem_enb) o.enb_cnt++;
    o.err      = rsp_err;
    o.rdata    = rsp_rdata;
    held_rdata = rsp_rdata;
    held_err   = rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge tb_clk); #1;
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_rdata", rsp_rdata, held_rdata);
      chk("hold_err", {31'd0, rsp_err}, {31'd0, held_err});
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
      if (data_mem_enb) o.enb_cnt++;
    end
    rsp_ready = 1'b1;
    @(posedge tb_clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_enb;
    logic [3:0]  exp_web;
    logic [31:0] exp_dinb;
  } vec_t;

  vec_t vecs [17];

  initial begin
    obs_t        o;
    logic        e_err;
    logic [31:0] e_rdata, e_dinb;
    logic [3:0]  e_web;
    string       nm;

    checks   = 0;
    failures = 0;
    for (int i = 0; i < MEM_DEPTH; i++) bram[i] = 32'd0;
    for (int i = 0; i < MEM_DEPTH*4; i++) ref_bytes[i] = 8'd0;
    data_mem_doutb = 32'd0;

    //          we    f3    addr               wdata          err   rdata         enb web      dinb
    vecs[0]  = '{1'b1, 3'd2, 32'h604,           32'hDEADBEEF,  1'b0, 32'h00000000, 1, 4'hF,   32'hDEADBEEF};
    vecs[1]  = '{1'b0, 3'd0, 32'h607,           32'h0,         1'b0, 32'hFFFFFFDE, 1, 4'h0,   32'h0};
    vecs[2]  = '{1'b0, 3'd4, 32'h607,           32'h0,         1'b0, 32'h000000DE, 1, 4'h0,   32'h0};
    vecs[3]  = '{1'b0, 3'd1, 32'h606,           32'h0,         1'b0, 32'hFFFFDEAD, 1, 4'h0,   32'h0};
    vecs[4]  = '{1'b0, 3'd5, 32'h604,           32'h0,         1'b0, 32'h0000BEEF, 1, 4'h0,   32'h0};
    vecs[5]  = '{1'b0, 3'd2, 32'h604,           32'h0,         1'b0, 32'hDEADBEEF, 1, 4'h0,   32'h0};
    vecs[6]  = '{1'b1, 3'd0, 32'h605,           32'h000000AA,  1'b0, 32'h00000000, 1, 4'b0010, 32'hAAAAAAAA};
    vecs[7]  = '{1'b1, 3'd1, 32'h606,           32'h00001234,  1'b0, 32'h00000000, 1, 4'b1100, 32'h12341234};
    vecs[8]  = '{1'b0, 3'd2, 32'h604,           32'h0,         1'b0, 32'h1234AAEF, 1, 4'h0,   32'h0};
    vecs[9]  = '{1'b0, 3'd1, 32'h601,           32'h0,         1'b1, 32'h00000000, 0, 4'h0,   32'h0};
    vecs[10] = '{1'b0, 3'd2, 32'h602,           32'h0,         1'b1, 32'h00000000, 0, 4'h0,   32'h0};
    vecs[11] = '{1'b0, 3'd2, 32'h5FC,           32'h0,         1'b1, 32'h00000000, 0, 4'h0,   32'h0};
    vecs[12] = '{1'b0, 3'd2, OFF + MEM_BYTES,   32'h0,         1'b1, 32'h00000000, 0, 4'h0,   32'h0};
    vecs[13] = '{1'b0, 3'd3, 32'h604,           32'h0,         1'b1, 32'h00000000, 0, 4'h0,   32'h0};
    vecs[14] = '{1'b1, 3'd4, 32'h604,           32'h000000AA,  1'b1, 32'h00000000, 0, 4'h0,   32'h0};
    vecs[15] = '{1'b1, 3'd2, OFF + MEM_BYTES - 4, 32'hCAFEF00D, 1'b0, 32'h00000000, 1, 4'hF,  32'hCAFEF00D};
    vecs[16] = '{1'b0, 3'd0, OFF + MEM_BYTES - 1, 32'h0,       1'b0, 32'hFFFFFFCA, 1, 4'h0,   32'h0};

    // ---------------- reset ----------------
    memory_offset      = OFF;
    req_valid          = 1'b0;
    req_we             = 1'b0;
    req_funct3         = 3'd0;
    req_addr           = 32'd0;
    req_wdata          = 32'd0;
    rsp_ready          = 1'b0;
    data_mem_rstb_busy = 1'b0;
    reset              = 1'b1;
    repeat (3) @(posedge tb_clk);
    #1;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_enb", {31'd0, data_mem_enb}, 32'd0);
    chk("rst_web", {28'd0, data_mem_web}, 32'd0);
    chk("rst_addrb", data_mem_addrb, 32'd0);
    chk("rst_dinb", data_mem_dinb, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    chk("rstb_tied", {31'd0, data_mem_rstb}, 32'd0);
    reset = 1'b0;
    @(posedge tb_clk); #1;
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);

    // ---------------- table ----------------
    for (int i = 0; i < 17; i++) begin
      do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, 0, o);
      ref_access(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, e_err, e_rdata, e_web, e_dinb);
      nm = $sformatf("vec%0d", i);
      chk({nm, "_err"}, {31'd0, o.err}, {31'd0, vecs[i].exp_err});
      chk({nm, "_rdata"}, o.rdata, vecs[i].exp_rdata);
      chk({nm, "_lat"}, o.lat, vecs[i].exp_err ? 0 : LEGAL_LAT);
      chk({nm, "_enb_cycles"}, o.enb_cnt, vecs[i].exp_enb);
      if (vecs[i].exp_enb != 0) begin
        chk({nm, "_web"}, {28'd0, o.web}, {28'd0, vecs[i].exp_web});
        chk({nm, "_addrb"}, o.addrb, vecs[i].addr - OFF);
        if (vecs[i].we) chk({nm, "_dinb"}, o.dinb, vecs[i].exp_dinb);
      end
    end

    // ---------------- backpressure + back-to-back ----------------
    do_req(1'b0, 3'd2, 32'h604, 32'h0, 3, o);
    ref_access(1'b0, 3'd2, 32'h604, 32'h0, e_err, e_rdata, e_web, e_dinb);
    chk("bp_rdata", o.rdata, e_rdata);
    chk("bp_err", {31'd0, o.err}, 32'd0);

    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h604;
    @(posedge tb_clk); #1;
    req_valid = 1'b0;
    data_mem_rstb_busy = 1'b1;   // busy rising mid-flight must not disturb the access
    begin
      int w;
      w = 0;
      while (!rsp_valid && w < 10) begin @(posedge tb_clk); #1; w++; end
    end
    chk("b2b_first_valid", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_first_rdata", rsp_rdata, e_rdata);
    data_mem_rstb_busy = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd4; req_addr = 32'h606;
    rsp_ready = 1'b1;
    @(posedge tb_clk); #1;
    rsp_ready = 1'b0;
    chk("b2b_handshake_valid", {31'd0, rsp_valid}, 32'd0);
    chk("b2b_no_accept_on_handshake", {31'd0, data_mem_enb}, 32'd0);
    chk("b2b_ready_after", {31'd0, req_ready}, 32'd1);
    @(posedge tb_clk); #1;
    req_valid = 1'b0;
    chk("b2b_accept_enb", {31'd0, data_mem_enb}, 32'd1);
    ref_access(1'b0, 3'd4, 32'h606, 32'h0, e_err, e_rdata, e_web, e_dinb);
    begin
      int w;
      w = 0;
      while (!rsp_valid && w < 10) begin @(posedge tb_clk); #1; w++; end
    end
    chk("b2b_second_rdata", rsp_rdata, e_rdata);
    rsp_ready = 1'b1;
    @(posedge tb_clk); #1;
    rsp_ready = 1'b0;

    // ---------------- busy blocks acceptance ----------------
    data_mem_rstb_busy = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h608; req_wdata = 32'h11111111;
    #1;
    chk("busy_req_ready", {31'd0, req_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge tb_clk); #1;
      chk("busy_no_enb", {31'd0, data_mem_enb}, 32'd0);
      chk("busy_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    req_valid = 1'b0;
    data_mem_rstb_busy = 1'b0;
    @(posedge tb_clk); #1;

    // ---------------- reset during ACCESS ----------------
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h604; req_wdata = 32'h55555555;
    @(posedge tb_clk); #1;
    req_valid = 1'b0;
    chk("mid_enb_before", {31'd0, data_mem_enb}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("mid_enb", {31'd0, data_mem_enb}, 32'd0);
    chk("mid_web", {28'd0, data_mem_web}, 32'd0);
    chk("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge tb_clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge tb_clk); #1;
      chk("mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    do_req(1'b0, 3'd2, 32'h604, 32'h0, 0, o);
    ref_access(1'b0, 3'd2, 32'h604, 32'h0, e_err, e_rdata, e_web, e_dinb);
    chk("post_rst_rdata", o.rdata, e_rdata);
    chk("post_rst_lat", o.lat, LEGAL_LAT);

    // ---------------- randomized against reference model ----------------
    for (int n = 0; n < 250; n++) begin
      logic        r_we;
      logic [2:0]  r_f3;
      logic [31:0] r_addr, r_wdata;
      r_we    = 1'($urandom_range(0, 1));
      r_wdata = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0: r_f3 = 3'd0;
          1: r_f3 = 3'd1;
          2: r_f3 = 3'd2;
          3: r_f3 = 3'd4;
          default: r_f3 = 3'd5;
        endcase
      end else begin
        r_f3 = 3'($urandom_range(0, 7));
      end
      case ($urandom_range(0, 9))
        0:       r_addr = OFF - 32'($urandom_range(1, 16));
        1:       r_addr = OFF + MEM_BYTES - 8 + 32'($urandom_range(0, 15));
        default: r_addr = OFF + 32'($urandom_range(0, 31));
      endcase
      do_req(r_we, r_f3, r_addr, r_wdata, $urandom_range(0, 2), o);
      ref_access(r_we, r_f3, r_addr, r_wdata, e_err, e_rdata, e_web, e_dinb);
      chk("rnd_err", {31'd0, o.err}, {31'd0, e_err});
      chk("rnd_rdata", o.rdata, e_rdata);
      chk("rnd_lat", o.lat, e_err ? 0 : LEGAL_LAT);
      chk("rnd_enb_cycles", o.enb_cnt, e_err ? 0 : 1);
      if (!e_err) begin
        chk("rnd_addrb", o.addrb, r_addr - OFF);
        chk("rnd_web", {28'd0, o.web}, {28'd0, e_web});
        if (r_we) chk("rnd_dinb", o.dinb, e_dinb);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
